// File: rtl/key_char_pkg.sv
// key_char_pkg: parser states, PS/2 set-2 scan constants and scan-to-ASCII lookup.
package key_char_pkg;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_e;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    // Letters come back lowercase; 0x00 marks an unmapped code.
    function automatic logic [7:0] scan_to_ascii(input logic [7:0] sc);
        case (sc)
            8'h1C: return 8'h61;
            8'h32: return 8'h62;
            8'h21: return 8'h63;
            8'h23: return 8'h64;
            8'h24: return 8'h65;
            8'h2B: return 8'h66;
            8'h34: return 8'h67;
            8'h33: return 8'h68;
            8'h43: return 8'h69;
            8'h3B: return 8'h6A;
            8'h42: return 8'h6B;
            8'h4B: return 8'h6C;
            8'h3A: return 8'h6D;
            8'h31: return 8'h6E;
            8'h44: return 8'h6F;
            8'h4D: return 8'h70;
            8'h15: return 8'h71;
            8'h2D: return 8'h72;
            8'h1B: return 8'h73;
            8'h2C: return 8'h74;
            8'h3C: return 8'h75;
            8'h2A: return 8'h76;
            8'h1D: return 8'h77;
            8'h22: return 8'h78;
            8'h35: return 8'h79;
            8'h1A: return 8'h7A;
            8'h45: return 8'h30;
            8'h16: return 8'h31;
            8'h1E: return 8'h32;
            8'h26: return 8'h33;
            8'h25: return 8'h34;
            8'h2E: return 8'h35;
            8'h36: return 8'h36;
            8'h3D: return 8'h37;
            8'h3E: return 8'h38;
            8'h46: return 8'h39;
            8'h29: return 8'h20;
            8'h5A: return 8'h0D;
            8'h66: return 8'h08;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/key_char_fifo.sv
// key_char_fifo: 4x8 show-ahead FIFO with occupancy count; head reads 0x00 when empty.
module key_char_fifo (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic [7:0] data_o,
    output logic [2:0] count_o,
    output logic       full_o,
    output logic       empty_o
);
    logic [7:0] mem_q [4];
    logic [1:0] wr_q, rd_q;
    logic [2:0] count_q;
    logic       pop_ok, push_ok;

    assign empty_o = count_q == 3'd0;
    assign full_o  = count_q == 3'd4;
    assign count_o = count_q;
    assign data_o  = empty_o ? 8'h00 : mem_q[rd_q];
    assign pop_ok  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= 2'd0;
            rd_q    <= 2'd0;
            count_q <= 3'd0;
        end else begin
            wr_q    <= wr_q + {1'b0, push_ok};
            rd_q    <= rd_q + {1'b0, pop_ok};
            count_q <= count_q + {2'b0, push_ok} - {2'b0, pop_ok};
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/key_char_ctrl.sv
// key_char_ctrl: PS/2 set-2 byte parser with shift/caps tracking feeding a character FIFO.
module key_char_ctrl
    import key_char_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    input  logic       char_ready,
    output logic       char_valid,
    output logic [7:0] char_data,
    output logic       mode_caps,
    output logic       shift_held,
    output logic [2:0] fifo_count,
    output logic       overflow
);
    state_e     state_q;
    logic       lsh_q, rsh_q, caps_held_q, mode_caps_q, ovf_q;
    logic       is_e0, is_f0, is_make, is_break, upper, letter, push, pop, full, empty;
    logic [7:0] lower, push_data;

    assign is_e0     = key_code == SC_EXT;
    assign is_f0     = key_code == SC_BRK;
    assign is_make   = key_valid && state_q == IDLE && !is_e0 && !is_f0;
    assign is_break  = key_valid && state_q == BRK;
    assign lower     = scan_to_ascii(key_code);
    assign letter    = lower >= 8'h61 && lower <= 8'h7A;
    assign upper     = mode_caps_q ^ shift_held;
    assign push_data = (upper && letter) ? lower - 8'h20 : lower;
    assign push      = is_make && lower != 8'h00;
    assign pop       = char_valid && char_ready;

    assign char_valid = !empty;
    assign mode_caps  = mode_caps_q;
    assign shift_held = lsh_q | rsh_q;
    assign overflow   = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lsh_q       <= 1'b0;
            rsh_q       <= 1'b0;
            caps_held_q <= 1'b0;
            mode_caps_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            if (key_valid)
                state_q <= (state_q == IDLE && is_e0) ? EXT :
                           (state_q == IDLE && is_f0) ? BRK :
                           (state_q == EXT  && is_f0) ? EXT_BRK : IDLE;
            lsh_q <= (is_make && key_code == SC_LSHIFT) ? 1'b1 :
                     (is_break && key_code == SC_LSHIFT) ? 1'b0 : lsh_q;
            rsh_q <= (is_make && key_code == SC_RSHIFT) ? 1'b1 :
                     (is_break && key_code == SC_RSHIFT) ? 1'b0 : rsh_q;
            // Typematic repeats of caps arrive as makes while held; only the first toggles.
            if (is_make && key_code == SC_CAPS && !caps_held_q) begin
                mode_caps_q <= ~mode_caps_q;
                caps_held_q <= 1'b1;
            end
            if (is_break && key_code == SC_CAPS) caps_held_q <= 1'b0;
            ovf_q <= push && full && !pop;
        end
    end

    key_char_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (char_data),
        .count_o (fifo_count),
        .full_o  (full),
        .empty_o (empty)
    );
endmodule

// File: tb/tb_key_char_ctrl.sv
// tb_key_char_ctrl: scoreboard bench; expected chars queued at drive time, checked on handshake.
module tb_key_char_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       key_valid = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       char_ready = 1'b0;
    logic       char_valid, mode_caps, shift_held, overflow;
    logic [7:0] char_data;
    logic [2:0] fifo_count;
    int         n_tests = 0;
    int         n_fail = 0;
    int         ovf_cnt = 0;
    logic [7:0] exp_q [$];

    key_char_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .char_ready (char_ready),
        .char_valid (char_valid),
        .char_data  (char_data),
        .mode_caps  (mode_caps),
        .shift_held (shift_held),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (overflow) ovf_cnt++;
            if (char_valid && char_ready) begin
                if (exp_q.size() == 0) check("spurious_char_qsize", exp_q.size(), 1);
                else check("char", char_data, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [7:0] c);
        key_valid = 1'b1;
        key_code  = c;
        @(posedge clk);
        #1 key_valid = 1'b0;
    endtask

    task automatic send_ch(input logic [7:0] c, input logic [7:0] ch);
        exp_q.push_back(ch);
        send(c);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1);
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        #2;
        check("rst_count", fifo_count, 0);
        check("rst_valid", char_valid, 0);
        check("rst_data", char_data, 8'h00);
        check("rst_caps", mode_caps, 0);
        check("rst_shift", shift_held, 0);
        check("rst_ovf", overflow, 0);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        char_ready = 1'b1;
        send_ch(8'h1C, 8'h61);
        check("a_latency_valid", char_valid, 1);
        send(8'hF0);
        send(8'h1C);
        drain("t28_drain");
        idle(3);
        check("t28_no_break_char", char_valid, 0);

        send(8'h58);
        send(8'h58);
        send(8'hF0);
        send(8'h58);
        check("caps_once", mode_caps, 1);
        send_ch(8'h1C, 8'h41);
        send(8'h12);
        check("lshift_held", shift_held, 1);
        send_ch(8'h1C, 8'h61);
        send(8'hF0);
        send(8'h12);
        check("lshift_released", shift_held, 0);
        send(8'h59);
        check("rshift_held", shift_held, 1);
        send_ch(8'h1C, 8'h61);
        send(8'hF0);
        send(8'h59);
        check("rshift_released", shift_held, 0);
        send(8'h58);
        send(8'hF0);
        send(8'h58);
        check("caps_off", mode_caps, 0);
        drain("t29_drain");

        send(8'hE0);
        send(8'h75);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        idle(2);
        check("ext_no_char", char_valid, 0);
        send_ch(8'h16, 8'h31);
        send(8'h12);
        send_ch(8'h1E, 8'h32);
        send(8'hF0);
        send(8'h12);
        send_ch(8'h29, 8'h20);
        send_ch(8'h5A, 8'h0D);
        send_ch(8'h66, 8'h08);
        send_ch(8'h1C, 8'h61);
        send_ch(8'h1C, 8'h61);
        send(8'h05);
        send(8'hE0);
        send(8'h1C);
        drain("t30_drain");
        idle(3);
        check("t30_empty", fifo_count, 0);

        char_ready = 1'b0;
        ovf_cnt = 0;
        send_ch(8'h1C, 8'h61);
        send_ch(8'h32, 8'h62);
        send_ch(8'h21, 8'h63);
        send_ch(8'h23, 8'h64);
        send(8'h24);
        send(8'h2B);
        idle(2);
        check("full_count", fifo_count, 4);
        check("ovf_pulses", ovf_cnt, 2);
        check("full_head", char_data, 8'h61);
        char_ready = 1'b1;
        send_ch(8'h34, 8'h67);
        check("full_pushpop_count", fifo_count, 4);
        drain("t31_drain");
        idle(1);
        check("t31_empty", fifo_count, 0);
        check("ovf_no_extra", ovf_cnt, 2);

        send(8'h58);
        send(8'hF0);
        send(8'h58);
        check("caps_on_again", mode_caps, 1);
        send(8'hF0);
        rst_n = 1'b0;
        #2;
        check("mid_rst_caps", mode_caps, 0);
        check("mid_rst_count", fifo_count, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        send_ch(8'h1C, 8'h61);
        check("post_rst_valid", char_valid, 1);
        check("post_rst_caps", mode_caps, 0);
        drain("t32_drain");
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/key_char_ctrl.md
KEY_CHAR_CTRL -- requirements
Module: key_char_ctrl

Interface
REQ-001 The block SHALL expose ports: clk  in  1  system clock, rising-edge active.
REQ-002 The block SHALL expose: rst_n  in  1  reset, asynchronous and active-low.
REQ-003 The block SHALL expose: key_valid  in  1  one-cycle strobe, key_code holds one PS/2 set-2 byte.
REQ-004 The block SHALL expose: key_code  in  8  scan byte (make, 0xF0 break prefix, 0xE0 extended prefix).
REQ-005 The block SHALL expose: char_ready  in  1  consumer accepts char_data when char_valid=1 and char_ready=1.
REQ-006 The block SHALL expose: char_valid  out  1  FIFO non-empty.
REQ-007 The block SHALL expose: char_data  out  8  ASCII at FIFO head (show-ahead).
REQ-008 The block SHALL expose: mode_caps  out  1  caps-lock state, 1 = uppercase.
REQ-009 The block SHALL expose: shift_held  out  1  either shift key currently down.
REQ-010 The block SHALL expose: fifo_count  out  3  occupancy 0..4.
REQ-011 The block SHALL expose: overflow  out  1  one-cycle pulse when a character is dropped.

Function
REQ-012 Parser FSM states: IDLE, EXT (0xE0 seen), BRK (0xF0 seen), EXT_BRK (0xE0 then 0xF0 seen); the parser SHALL change state only on cycles with key_valid=1.
REQ-013 Transitions: IDLE and 0xE0 -> EXT; IDLE and 0xF0 -> BRK; EXT and 0xF0 -> EXT_BRK; any other byte -> IDLE after acting on it as make (IDLE), break (BRK), or discard (EXT, EXT_BRK).
REQ-014 Shift: make 0x12 or 0x59 SHALL set that key's held bit; break SHALL clear it; shift_held = OR of both bits.
REQ-015 Caps: make 0x58 with caps_held=0 SHALL toggle mode_caps and set caps_held; make 0x58 with caps_held=1 (typematic repeat) SHALL NOT toggle; break 0x58 SHALL clear caps_held.
REQ-016 Letter make codes (a-z) SHALL push uppercase ASCII when (mode_caps XOR shift_held)=1, else lowercase, using values in effect before the current byte.
REQ-017 Digits 0-9 SHALL push '0'-'9' regardless of shift; 0x29 -> 0x20, 0x5A -> 0x0D, 0x66 -> 0x08; each typematic make SHALL push again.
REQ-018 Unmapped makes, all breaks and all extended codes SHALL push nothing.
REQ-019 A pushed character SHALL appear on char_data/char_valid on the cycle after the key_valid cycle; there is no same-cycle bypass.
REQ-020 FIFO depth 4, in order; pop occurs when char_valid and char_ready are both 1.
REQ-021 Push while full without simultaneous pop SHALL drop the character and pulse overflow for one cycle; push with simultaneous pop while full SHALL be accepted, count stays 4.
REQ-022 Pop while empty SHALL be ignored; simultaneous push and pop at count 1..3 SHALL leave count unchanged.
REQ-023 Pointers SHALL wrap modulo 4; fifo_count = number of stored entries.

Reset
REQ-024 rst_n=0 SHALL immediately force parser to IDLE, mode_caps=0, shift and caps held bits=0, FIFO empty (fifo_count=0, char_valid=0), overflow=0, char_data=0x00.
REQ-025 Reset asserted mid-sequence (e.g. after 0xF0) SHALL discard the pending prefix; the first byte after release SHALL be parsed from IDLE.

Structure
REQ-026 Package key_char_pkg SHALL hold parser state encodings, scan-code constants (0xE0, 0xF0, 0x12, 0x59, 0x58) and the scan-to-ASCII lookup function.
REQ-027 The FIFO SHALL be a sub-module key_char_fifo (4x8, show-ahead, count, full/empty); parser, mode registers and lookup stay in key_char_ctrl.

Verification
REQ-028 Bytes 0x1C, 0xF0, 0x1C with char_ready=1 -> one char 0x61 ('a'), one cycle after first byte; no output for the break.
REQ-029 0x58, 0x58, 0xF0, 0x58, then 0x1C -> mode_caps=1 (toggled once), char 0x41; then 0x12, 0x1C -> char 0x61 (caps XOR shift).
REQ-030 0xE0, 0x75, 0xE0, 0xF0, 0x75 -> no char, parser back in IDLE, next 0x16 -> 0x31.
REQ-031 char_ready=0, six letter makes -> fifo_count=4, overflow pulses twice, first four chars drained in order; push+pop at full accepted.
REQ-032 Reset asserted after 0xF0, released, then 0x1C -> char 0x61 (not treated as break), mode_caps=0.
